alarm_sw_debounce: RTL and testbench

ALARM_SW_DEBOUNCE -- requirements
Module: alarm_sw_debounce

---
 rtl/alarm_io_pkg.sv | 16 +
 rtl/alarm_sw_debounce_ch.sv | 95 +++++++++
 rtl/alarm_sw_debounce.sv | 37 +++
 tb/tb_alarm_sw_debounce.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/alarm_io_pkg.sv
// rtl/alarm_io_pkg.sv - shared constants, FSM states and helpers for the alarm I/O blocks
package alarm_io_pkg;

  // 10 ms stability window at the 50 MHz system clock
  localparam int DEB_CYCLES_DEFAULT = 500000;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } deb_state_e;

  function automatic int cnt_width(input int deb_cycles);
    return (deb_cycles < 1) ? 1 : $clog2(deb_cycles + 1);
  endfunction

endpackage

// File: rtl/alarm_sw_debounce_ch.sv
// rtl/alarm_sw_debounce_ch.sv - one switch channel: synchronizer, stability counter, edge pulses
import alarm_io_pkg::*;

module alarm_sw_debounce_ch #(
  parameter int DEB_CYCLES  = DEB_CYCLES_DEFAULT,
  parameter int SYNC_STAGES = 2,
  parameter bit RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sw_raw,
  output logic sw_level,
  output logic sw_rise,
  output logic sw_fall
);

  localparam int CW = cnt_width(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  deb_state_e             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw_raw};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // The counter saturates at CNT_MAX by construction: acceptance clears it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (sync != level_q) begin
          state_d = COUNT;
          cnt_d   = CNT_ONE;
        end
      end
      COUNT: begin
        if (sync == level_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_MAX) begin
          state_d = IDLE;
          cnt_d   = '0;
          level_d = sync;
          rise_d  = sync;
          fall_d  = ~sync;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign sw_level = level_q;
  assign sw_rise  = rise_q;
  assign sw_fall  = fall_q;

endmodule

// File: rtl/alarm_sw_debounce.sv
// rtl/alarm_sw_debounce.sv - multi-channel switch debouncer feeding the PIO in_port
import alarm_io_pkg::*;

module alarm_sw_debounce #(
  parameter int NUM_SW      = 4,
  parameter int DEB_CYCLES  = DEB_CYCLES_DEFAULT,
  parameter int SYNC_STAGES = 2,
  parameter bit RESET_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_SW-1:0] sw_raw,
  output logic [NUM_SW-1:0] sw_level,
  output logic [NUM_SW-1:0] sw_rise,
  output logic [NUM_SW-1:0] sw_fall,
  output logic              sw_changed
);

  for (genvar i = 0; i < NUM_SW; i++) begin : g_ch
    alarm_sw_debounce_ch #(
      .DEB_CYCLES (DEB_CYCLES),
      .SYNC_STAGES(SYNC_STAGES),
      .RESET_LEVEL(RESET_LEVEL)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .sw_raw  (sw_raw[i]),
      .sw_level(sw_level[i]),
      .sw_rise (sw_rise[i]),
      .sw_fall (sw_fall[i])
    );
  end

  // Pulses are already registered, so this OR lands in the same cycle as they do.
  assign sw_changed = |(sw_rise | sw_fall);

endmodule

// File: tb/tb_alarm_sw_debounce.sv
// tb/tb_alarm_sw_debounce.sv - directed bench for alarm_sw_debounce (4 channels, DEB_CYCLES=4, plus DEB_CYCLES=1)
module tb_alarm_sw_debounce;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] sw_raw = 4'b0000;
  logic [3:0] sw_level, sw_rise, sw_fall;
  logic       sw_changed;

  logic [0:0] sw_raw1 = 1'b0;
  logic [0:0] sw_level1, sw_rise1, sw_fall1;
  logic       sw_changed1;

  int n_checks = 0;
  int n_fail   = 0;

  int         first_lvl, rise_n, fall_n, chg_n, rise_at, fall_at, chg_at, both_n;
  int         rise_cyc_n;
  logic [3:0] rise_mask;

  always #5 clk = ~clk;

  alarm_sw_debounce #(
    .NUM_SW(4), .DEB_CYCLES(4), .SYNC_STAGES(2), .RESET_LEVEL(1'b0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sw_raw(sw_raw),
    .sw_level(sw_level), .sw_rise(sw_rise), .sw_fall(sw_fall), .sw_changed(sw_changed)
  );

  alarm_sw_debounce #(
    .NUM_SW(1), .DEB_CYCLES(1), .SYNC_STAGES(2), .RESET_LEVEL(1'b0)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .sw_raw(sw_raw1),
    .sw_level(sw_level1), .sw_rise(sw_rise1), .sw_fall(sw_fall1), .sw_changed(sw_changed1)
  );

  // Counter bound held every cycle on both builds
  always @(negedge clk) begin
    if (reset_n) begin
      n_checks++;
      if (int'(dut1.g_ch[0].u_ch.cnt_q) > 1) begin
        n_fail++;
        $display("FAIL cnt_bound_deb1: got %0d max 1", int'(dut1.g_ch[0].u_ch.cnt_q));
      end
      n_checks++;
      if (int'(dut.g_ch[2].u_ch.cnt_q) > 4) begin
        n_fail++;
        $display("FAIL cnt_bound_deb4: got %0d max 4", int'(dut.g_ch[2].u_ch.cnt_q));
      end
    end
  end

  task automatic watch(input int n, input int ch, input bit lvl_target);
    first_lvl = -1; rise_n = 0; fall_n = 0; chg_n = 0;
    rise_at = -1; fall_at = -1; chg_at = -1; both_n = 0;
    rise_cyc_n = 0; rise_mask = 4'b0000;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (sw_level[ch] == lvl_target && first_lvl < 0) first_lvl = i;
      if (sw_rise[ch]) begin rise_n++; rise_at = i; end
      if (sw_fall[ch]) begin fall_n++; fall_at = i; end
      if (sw_changed) begin chg_n++; chg_at = i; end
      if ((sw_rise & sw_fall) != 4'b0000) both_n++;
      if (sw_rise != 4'b0000) begin rise_cyc_n++; rise_mask = sw_rise; end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    sw_raw  = 4'b0000;
    repeat (3) @(negedge clk);
    n_checks++; if (sw_level !== 4'b0000) begin n_fail++; $display("FAIL reset_level: got %b expected 0000", sw_level); end
    n_checks++; if (sw_rise !== 4'b0000) begin n_fail++; $display("FAIL reset_rise: got %b expected 0000", sw_rise); end
    n_checks++; if (sw_fall !== 4'b0000) begin n_fail++; $display("FAIL reset_fall: got %b expected 0000", sw_fall); end
    n_checks++; if (sw_changed !== 1'b0) begin n_fail++; $display("FAIL reset_changed: got %b expected 0", sw_changed); end
    reset_n = 1'b1;
  endtask

  task automatic test_idle;
    watch(20, 0, 1'b1);
    n_checks++; if (chg_n != 0) begin n_fail++; $display("FAIL idle_pulses: got %0d expected 0", chg_n); end
    n_checks++; if (first_lvl != -1 || sw_level !== 4'b0000) begin n_fail++; $display("FAIL idle_level: got %b expected 0000", sw_level); end
  endtask

  task automatic test_press;
    sw_raw[0] = 1'b1;
    watch(12, 0, 1'b1);
    n_checks++; if (first_lvl != 7) begin n_fail++; $display("FAIL press_latency: got %0d expected 7", first_lvl); end
    n_checks++; if (rise_n != 1 || rise_at != 7) begin n_fail++; $display("FAIL press_rise: got %0d pulses at %0d expected 1 at 7", rise_n, rise_at); end
    n_checks++; if (chg_n != 1 || chg_at != 7) begin n_fail++; $display("FAIL press_changed: got %0d at %0d expected 1 at 7", chg_n, chg_at); end
    n_checks++; if (fall_n != 0 || both_n != 0) begin n_fail++; $display("FAIL press_nofall: got fall %0d both %0d expected 0 0", fall_n, both_n); end
    sw_raw[0] = 1'b0;
    watch(12, 0, 1'b0);
    n_checks++; if (first_lvl != 7) begin n_fail++; $display("FAIL release_latency: got %0d expected 7", first_lvl); end
    n_checks++; if (fall_n != 1 || fall_at != 7 || rise_n != 0) begin n_fail++; $display("FAIL release_fall: got fall %0d at %0d rise %0d expected 1 at 7, 0", fall_n, fall_at, rise_n); end
    n_checks++; if (chg_n != 1) begin n_fail++; $display("FAIL release_changed: got %0d expected 1", chg_n); end
  endtask

  task automatic test_bounce;
    int bounce_pulses;
    bounce_pulses = 0;
    for (int i = 0; i < 8; i++) begin
      sw_raw[1] = ((i / 2) % 2 == 0);
      @(negedge clk);
      if (sw_changed || sw_level[1]) bounce_pulses++;
    end
    n_checks++; if (bounce_pulses != 0) begin n_fail++; $display("FAIL bounce_quiet: got %0d events expected 0", bounce_pulses); end
    sw_raw[1] = 1'b1;
    watch(12, 1, 1'b1);
    n_checks++; if (first_lvl != 7) begin n_fail++; $display("FAIL bounce_latency: got %0d expected 7", first_lvl); end
    n_checks++; if (rise_n != 1 || rise_at != 7) begin n_fail++; $display("FAIL bounce_rise: got %0d at %0d expected 1 at 7", rise_n, rise_at); end
    sw_raw[1] = 1'b0;
    watch(12, 1, 1'b0);
    n_checks++; if (fall_n != 1 || first_lvl != 7) begin n_fail++; $display("FAIL bounce_fall: got %0d level at %0d expected 1 at 7", fall_n, first_lvl); end
  endtask

  task automatic test_simultaneous;
    sw_raw = 4'b1111;
    watch(12, 3, 1'b1);
    n_checks++; if (rise_cyc_n != 1 || rise_mask !== 4'b1111) begin n_fail++; $display("FAIL simul_rise: got %0d cycles mask %b expected 1 cycle 1111", rise_cyc_n, rise_mask); end
    n_checks++; if (chg_n != 1 || chg_at != 7) begin n_fail++; $display("FAIL simul_changed: got %0d at %0d expected 1 at 7", chg_n, chg_at); end
    n_checks++; if (sw_level !== 4'b1111 || both_n != 0) begin n_fail++; $display("FAIL simul_level: got %b both %0d expected 1111 0", sw_level, both_n); end
    sw_raw = 4'b0000;
    watch(12, 3, 1'b0);
    n_checks++; if (chg_n != 1 || sw_level !== 4'b0000) begin n_fail++; $display("FAIL simul_release: got %0d changes level %b expected 1 0000", chg_n, sw_level); end
  endtask

  task automatic test_reset_midcount;
    sw_raw[2] = 1'b1;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_checks++; if (sw_level[2] !== 1'b0 || sw_changed !== 1'b0) begin n_fail++; $display("FAIL midrst_hold: got level %b chg %b expected 0 0", sw_level[2], sw_changed); end
    n_checks++; if (int'(dut.g_ch[2].u_ch.cnt_q) != 0) begin n_fail++; $display("FAIL midrst_cnt: got %0d expected 0", int'(dut.g_ch[2].u_ch.cnt_q)); end
    repeat (2) @(negedge clk);
    n_checks++; if (sw_level[2] !== 1'b0 || sw_rise[2] !== 1'b0) begin n_fail++; $display("FAIL midrst_during: got level %b rise %b expected 0 0", sw_level[2], sw_rise[2]); end
    reset_n = 1'b1;
    watch(12, 2, 1'b1);
    n_checks++; if (first_lvl != 7) begin n_fail++; $display("FAIL midrst_latency: got %0d expected 7", first_lvl); end
    n_checks++; if (rise_n != 1 || rise_at != 7) begin n_fail++; $display("FAIL midrst_rise: got %0d at %0d expected 1 at 7", rise_n, rise_at); end
    sw_raw[2] = 1'b0;
    watch(12, 2, 1'b0);
  endtask

  task automatic test_deb1;
    int r_n, r_at, f_n, f_at;
    r_n = 0; r_at = -1; f_n = 0; f_at = -1;
    for (int i = 1; i <= 10; i++) begin
      sw_raw1 = (i <= 1);
      @(negedge clk);
      if (sw_rise1[0] || sw_changed1) r_n++;
    end
    n_checks++; if (r_n != 0 || sw_level1 !== 1'b0) begin n_fail++; $display("FAIL deb1_short_glitch: got %0d events level %b expected 0 0", r_n, sw_level1); end
    r_n = 0;
    for (int i = 1; i <= 10; i++) begin
      sw_raw1 = (i <= 2);
      @(negedge clk);
      if (sw_rise1[0]) begin r_n++; r_at = i; end
      if (sw_fall1[0]) begin f_n++; f_at = i; end
    end
    n_checks++; if (r_n != 1 || r_at != 4) begin n_fail++; $display("FAIL deb1_accept_rise: got %0d at %0d expected 1 at 4", r_n, r_at); end
    n_checks++; if (f_n != 1 || f_at != 6) begin n_fail++; $display("FAIL deb1_accept_fall: got %0d at %0d expected 1 at 6", f_n, f_at); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_press();
    test_bounce();
    test_simultaneous();
    test_reset_midcount();
    test_deb1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
